hf14a_tag_frame_decoder: RTL
============================

// Module: hf14a_tag_frame_decoder
// PURPOSE
//  Downstream of the HF front end's 848kHz modulation detector. Consumes one curbit per 16-carrier-clock
//  slot and decodes ISO14443-A tag->reader Manchester: SOF, data bits, odd parity, EOF.
//  Emits whole bytes, partial final bytes, parity and collision flags to the ARM-side SSP/capture logic.
// PARAMETERS
//  SLOTS_PER_HALF   4   slots (16 fc each) per half-bit; bit period = 2*SLOTS_PER_HALF slots = 128 fc
//  MAJORITY         2   modulated slots in a half-bit needed to call that half "modulated"
//  MAX_FRAME_BYTES  64  frame_bytes saturation value; sets the counter width
// PORTS
//  ck_1356meg   in   1   13.56MHz carrier clock; all logic on posedge
//  reset        in   1   asynchronous, active-high
//  sample_valid in   1   1-cycle strobe, once per 16 fc (negedge_cnt[3:0]==0 equivalent)
//  curbit       in   1   modulation detected in the slot just closed; sampled only with sample_valid
//  rx_active    out  1   high from SOF detection until frame_end or abort
//  byte_valid   out  1   1-cycle pulse: byte_data/byte_bits/parity_err valid
//  byte_data    out  8   received byte, LSB first on air
//  byte_bits    out  4   valid data bits in byte_data (8 full, 1..7 partial final byte)
//  parity_err   out  1   with byte_valid: odd parity failed (always 0 when byte_bits<8)
//  collision    out  1   sticky per frame: some bit had both halves modulated; cleared at next SOF
//  frame_end    out  1   1-cycle pulse on EOF
//  frame_bytes  out  7   bytes emitted this frame, saturating at MAX_FRAME_BYTES; cleared at SOF
// BEHAVIOUR
//  - Reset: state IDLE, all counters 0; every output 0. Reset beats simultaneous sample_valid.
//    Reset mid-frame discards the partial byte; no frame_end.
//  - Half classifier: slot_cnt counts sample_valid 0..SLOTS_PER_HALF-1, mod_cnt counts curbit=1.
//    At the last slot: h = (mod_cnt + curbit >= MAJORITY); both counters cleared.
//  - Decoder FSM, advancing only on sample_valid:
//    IDLE:   slot_cnt held 0. First curbit=1 -> SOF_H1, slot_cnt=1, mod_cnt=1 (aligns half-bits).
//            Set rx_active; clear collision and frame_bytes.
//    SOF_H1: half done: h=1 -> SOF_H2; h=0 -> IDLE (glitch, rx_active=0, no pulses).
//    SOF_H2: half done: h=0 -> D_H1; h=1 -> IDLE (abort, no frame_end).
//    D_H1:   half done: store h1 -> D_H2.
//    D_H2:   half done: (h1,h2) 10 -> bit 1; 01 -> bit 0; 11 -> bit 1 and collision=1; 00 -> EOF.
//            Bit: shift into {parity,data}, bit_cnt++, -> D_H1.
//            bit_cnt 9: byte_valid, byte_bits=8, parity_err = ~^{parity,data}; bit_cnt=0.
//            EOF: if bit_cnt in 1..8, byte_valid with raw data bits only (no parity check), byte_bits=bit_cnt.
//            Then frame_end, rx_active=0 -> IDLE.
//  - Latency: byte_valid/frame_end are registered, one clock after the sample_valid that closes the half-bit.
//    A partial-byte byte_valid and frame_end share the same clock.
//  - frame_bytes increments on each byte_valid and saturates; no wrap.
//  - byte_data/byte_bits/parity_err hold their value between pulses.
// STRUCTURE
//  - Shared package hf14a_pkg: state encoding (IDLE, SOF_H1, SOF_H2, D_H1, D_H2),
//    SLOTS_PER_HALF default, ISO14443A odd-parity helper.
//  - One sub-module, hf14a_half_classifier: slot/mod counters -> half_done, h.
//    The FSM, shifter and byte counter stay in this module.
// TESTING
//  Notation: bit1 = slots 1111_0000, bit0 = 0000_1111, EOF = 0000_0000; SOF = bit1. Bits LSB first.
//  1 SOF, 0x04, parity 0, EOF
//    -> byte_valid, byte_data=0x04, byte_bits=8, parity_err=0, then frame_end; frame_bytes=1.
//  2 As 1 with parity bit 1 -> parity_err=1; 0x44,0x00 (ATQA) -> frame_bytes=2.
//    Slot pattern 1011_0000 decodes as bit1 (majority).
//  3 Single 1 slot then zeros -> rx_active drops after 4 slots; no byte_valid, no frame_end.
//  4 SOF, bit 3 sent as 1111_1111 -> collision=1, byte_data bit3=1; collision cleared at next SOF.
//  5 SOF, 5 bits 10110 (LSB first), EOF -> byte_valid, byte_bits=5, byte_data[4:0]=5'b01101, parity_err=0;
//    frame_end in the same cycle.
//  6 Reset mid-byte (after 4 bits) -> all outputs 0, no frame_end; the next frame from case 1 decodes as 0x04.

Source files
------------

// File: rtl/hf14a_pkg.sv
// hf14a_pkg: state encoding, parameter defaults and odd-parity helper for the 14443-A tag frame decoder
package hf14a_pkg;

    typedef enum logic [2:0] {IDLE, SOF_H1, SOF_H2, D_H1, D_H2} state_t;

    localparam int SLOTS_PER_HALF_DEF  = 4;
    localparam int MAJORITY_DEF        = 2;
    localparam int MAX_FRAME_BYTES_DEF = 64;

    // parity bit that makes {parity, data} contain an odd number of ones
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/hf14a_half_classifier.sv
// hf14a_half_classifier: groups slots into half-bits and votes each half modulated or not
module hf14a_half_classifier
    import hf14a_pkg::*;
#(
    parameter int SLOTS_PER_HALF = SLOTS_PER_HALF_DEF,
    parameter int MAJORITY       = MAJORITY_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sample_valid,
    input  logic i_curbit,
    input  logic i_idle,
    output logic o_half_done,
    output logic o_h
);

    localparam int CW = $clog2(SLOTS_PER_HALF + 1);

    logic [CW-1:0] r_slot_cnt;
    logic [CW-1:0] r_mod_cnt;
    logic          w_start;

    assign w_start     = i_sample_valid && i_curbit;
    assign o_half_done = i_sample_valid && !i_idle && (r_slot_cnt == CW'(SLOTS_PER_HALF - 1));
    assign o_h         = (int'(r_mod_cnt) + int'(i_curbit)) >= MAJORITY;

    // counters idle at 0; the first modulated slot counts as slot 0 of the SOF half so halves line up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_cnt <= '0;
            r_mod_cnt  <= '0;
        end else if (i_idle) begin
            r_slot_cnt <= w_start ? CW'(1) : '0;
            r_mod_cnt  <= w_start ? CW'(1) : '0;
        end else if (i_sample_valid) begin
            r_slot_cnt <= o_half_done ? '0 : r_slot_cnt + CW'(1);
            r_mod_cnt  <= o_half_done ? '0 : r_mod_cnt + CW'(i_curbit);
        end
    end

endmodule

// File: rtl/hf14a_tag_frame_decoder.sv
// hf14a_tag_frame_decoder: decodes tag->reader Manchester (SOF, data, odd parity, EOF) into bytes
module hf14a_tag_frame_decoder
    import hf14a_pkg::*;
#(
    parameter int SLOTS_PER_HALF  = SLOTS_PER_HALF_DEF,
    parameter int MAJORITY        = MAJORITY_DEF,
    parameter int MAX_FRAME_BYTES = MAX_FRAME_BYTES_DEF
) (
    input  logic       ck_1356meg,
    input  logic       reset,
    input  logic       sample_valid,
    input  logic       curbit,
    output logic       rx_active,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic [3:0] byte_bits,
    output logic       parity_err,
    output logic       collision,
    output logic       frame_end,
    output logic [6:0] frame_bytes
);

    state_t     r_state, w_state;
    logic       r_h1, w_h1;
    logic [7:0] r_sh, w_sh;
    logic [3:0] r_bit_cnt, w_bit_cnt;
    logic       r_rx, w_rx;
    logic       r_bv, w_bv;
    logic       r_fe, w_fe;
    logic [7:0] r_data, w_data;
    logic [3:0] r_bits, w_bits;
    logic       r_perr, w_perr;
    logic       r_coll, w_coll;
    logic [6:0] r_fb, w_fb;
    logic       w_half_done;
    logic       w_h;

    hf14a_half_classifier #(
        .SLOTS_PER_HALF (SLOTS_PER_HALF),
        .MAJORITY       (MAJORITY)
    ) u_half (
        .clk            (ck_1356meg),
        .rst            (reset),
        .i_sample_valid (sample_valid),
        .i_curbit       (curbit),
        .i_idle         (r_state == IDLE),
        .o_half_done    (w_half_done),
        .o_h            (w_h)
    );

    // all decoder state and outputs are registered, so pulses land one clock after the closing slot
    always_ff @(posedge ck_1356meg or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_h1      <= 1'b0;
            r_sh      <= '0;
            r_bit_cnt <= '0;
            r_rx      <= 1'b0;
            r_bv      <= 1'b0;
            r_fe      <= 1'b0;
            r_data    <= '0;
            r_bits    <= '0;
            r_perr    <= 1'b0;
            r_coll    <= 1'b0;
            r_fb      <= '0;
        end else begin
            r_state   <= w_state;
            r_h1      <= w_h1;
            r_sh      <= w_sh;
            r_bit_cnt <= w_bit_cnt;
            r_rx      <= w_rx;
            r_bv      <= w_bv;
            r_fe      <= w_fe;
            r_data    <= w_data;
            r_bits    <= w_bits;
            r_perr    <= w_perr;
            r_coll    <= w_coll;
            r_fb      <= w_fb;
        end
    end

    // frame FSM: SOF check, half-bit pairing, byte assembly with parity, EOF with partial-byte flush
    always_comb begin
        w_state   = r_state;
        w_h1      = r_h1;
        w_sh      = r_sh;
        w_bit_cnt = r_bit_cnt;
        w_rx      = r_rx;
        w_bv      = 1'b0;
        w_fe      = 1'b0;
        w_data    = r_data;
        w_bits    = r_bits;
        w_perr    = r_perr;
        w_coll    = r_coll;
        w_fb      = r_fb;
        case (r_state)
            IDLE: if (sample_valid && curbit) begin
                w_state   = SOF_H1;
                w_rx      = 1'b1;
                w_coll    = 1'b0;
                w_fb      = '0;
                w_sh      = '0;
                w_bit_cnt = '0;
            end
            SOF_H1: if (w_half_done) begin
                w_state = w_h ? SOF_H2 : IDLE;
                w_rx    = w_h;
            end
            SOF_H2: if (w_half_done) begin
                w_state = w_h ? IDLE : D_H1;
                w_rx    = !w_h;
            end
            D_H1: if (w_half_done) begin
                w_h1    = w_h;
                w_state = D_H2;
            end
            D_H2: if (w_half_done) begin
                if (!r_h1 && !w_h) begin
                    w_bv      = r_bit_cnt != 4'd0;
                    w_data    = r_sh >> (4'd8 - r_bit_cnt);
                    w_bits    = w_bv ? r_bit_cnt : r_bits;
                    w_perr    = w_bv ? 1'b0 : r_perr;
                    w_data    = w_bv ? w_data : r_data;
                    w_bit_cnt = '0;
                    w_fe      = 1'b1;
                    w_rx      = 1'b0;
                    w_state   = IDLE;
                end else begin
                    w_coll  = r_coll | (r_h1 & w_h);
                    w_state = D_H1;
                    if (r_bit_cnt == 4'd8) begin
                        w_bv      = 1'b1;
                        w_data    = r_sh;
                        w_bits    = 4'd8;
                        w_perr    = r_h1 != odd_parity(r_sh);
                        w_bit_cnt = '0;
                    end else begin
                        w_sh      = {r_h1, r_sh[7:1]};
                        w_bit_cnt = r_bit_cnt + 4'd1;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
        if (w_bv && r_fb != 7'(MAX_FRAME_BYTES))
            w_fb = r_fb + 7'd1;
    end

    assign rx_active   = r_rx;
    assign byte_valid  = r_bv;
    assign byte_data   = r_data;
    assign byte_bits   = r_bits;
    assign parity_err  = r_perr;
    assign collision   = r_coll;
    assign frame_end   = r_fe;
    assign frame_bytes = r_fb;

endmodule
